apb_master_port: RTL and testbench
==================================

Name: apb_master_port

Overview:
- Single-outstanding APB initiator. Converts a simple valid/ready request/response interface into APB SETUP/ACCESS transfers.
- Lets an on-chip agent (debug bridge, DMA-lite, wakeup sequencer) program APB peripherals such as the event unit without a core on the bus.
- Handles wait states, PSLVERR, misaligned-request rejection, and a stuck-slave timeout.

Parameters:
APB_ADDR_WIDTH, 12, width of req_addr_i and PADDR
TIMEOUT_CYCLES, 255, ACCESS wait-state limit before abort; 0 disables the timeout
TIMEOUT_W, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_W

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted when high together with req_valid_i
req_addr_i  in  APB_ADDR_WIDTH  byte address
req_we_i  in  1  1 = write, 0 = read
req_wdata_i  in  32  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when high together with rsp_valid_o
rsp_rdata_o  out  32  read data; 0 for writes and errors
rsp_err_o  out  1  PSLVERR, misaligned request, or timeout
rsp_timeout_o  out  1  abort caused by timeout
busy_o  out  1  FSM not in IDLE
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  32  APB write data
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Clock and reset: one clock, HCLK. Reset is HRESET, synchronous and active-high, sampled on the HCLK rising edge.
- Reset values: FSM=IDLE. PSEL, PENABLE, PWRITE=0. PADDR, PWDATA=0. rsp_valid_o, rsp_err_o, rsp_timeout_o=0. rsp_rdata_o=0. Timeout counter=0.
- req_ready_o is forced 0 while HRESET is high.
- All APB outputs and rsp_* outputs are registered.
- FSM states:
  - IDLE: req_ready_o=1, busy_o=0.
    - Handshake with req_addr_i[1:0]==0: latch addr/we/wdata into PADDR/PWRITE/PWDATA (PWDATA=0 for reads) -> SETUP.
    - Handshake with req_addr_i[1:0]!=0: no APB transfer -> RESP with err=1, timeout=0, rdata=0.
  - SETUP: PSEL=1, PENABLE=0, one cycle -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stable from SETUP through the end of ACCESS.
    - PREADY=0: counter increments.
    - PREADY=1: capture rdata=PRDATA for reads (0 for writes) and err=PSLVERR, timeout=0; drop PSEL/PENABLE -> RESP.
    - Counter reaches TIMEOUT_CYCLES with PREADY still 0 and TIMEOUT_CYCLES!=0: abort; drop PSEL/PENABLE -> RESP with err=1, timeout=1, rdata=0.
    - PREADY=1 on the same cycle the limit is hit: the completion wins and the response is a normal one.
  - RESP: rsp_valid_o=1, PSEL=0, PENABLE=0. rsp_* held stable until rsp_ready_i=1, then -> IDLE and rsp_valid_o=0.
- Counter clears on entry to SETUP.
- Latency: the minimum from handshake edge to rsp_valid_o high is 3 cycles (SETUP, ACCESS with PREADY=1, RESP).
- Throughput: next request accepted the cycle after the response handshake. Maximum one transfer per 4 cycles.
- req_ready_o=0 in SETUP, ACCESS and RESP. req_valid_i is ignored there and the request must stay held by the requester.
- PADDR, PWDATA and PWRITE keep their last values in IDLE and RESP.
- rsp_valid_o is never combinationally dependent on rsp_ready_i.
- Reset mid-operation (any state): next edge returns IDLE with all outputs at reset values. In-flight transfer and pending response are discarded with no response issued.
- A timeout abort is a deliberate APB protocol violation for fault recovery only. The bench must not flag it as a checker error.

Test Plan:
- Read, zero wait: req addr=0x104, we=0; slave PREADY=1, PRDATA=0xDEADBEEF -> PSEL high 2 cycles, PENABLE in the 2nd; rsp_valid 3 cycles after handshake; rdata=0xDEADBEEF, err=0.
- Write, 3 wait states: addr=0x008, wdata=0x00000005; PREADY low 3 ACCESS cycles -> PADDR/PWDATA/PWRITE stable for all 5 PSEL cycles; rsp rdata=0, err=0.
- Error cases:
  - PSLVERR=1 with PREADY=1 on a read -> err=1, timeout=0, rdata=0.
  - Misaligned addr=0x006 -> PSEL never asserts; rsp err=1 after 1 cycle.
- Timeout, TIMEOUT_CYCLES=4, PREADY held 0 -> exactly 4 ACCESS cycles, then PSEL=0; rsp err=1, timeout=1. Repeat with PREADY=1 on the 4th cycle -> normal response, timeout=0.
- Backpressure: rsp_ready_i low 10 cycles in RESP -> rsp_* stable, req_ready_o=0, no new PSEL. Release -> IDLE next cycle; a back-to-back request is accepted that cycle.
- Reset mid-ACCESS with PREADY=0 -> next edge PSEL=0, PENABLE=0, rsp_valid=0, req_ready_o=1 once HRESET deasserts; no stale response afterwards.

Source files
------------

// File: rtl/apb_master_port.sv
// apb_master_port: single-outstanding APB initiator.
// Converts a valid/ready request/response interface into APB SETUP/ACCESS
// transfers. It also handles wait states, PSLVERR, rejection of misaligned
// requests, and an abort when a slave stays stuck for too long.
module apb_master_port #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_we_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // The abort fires on the ACCESS cycle where the counter holds
  // TIMEOUT_CYCLES-1. That gives exactly TIMEOUT_CYCLES ACCESS cycles.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e                      state_q, state_d;
  logic                        psel_q, psel_d;
  logic                        penable_q, penable_d;
  logic                        pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [31:0]                 pwdata_q, pwdata_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_err_q, rsp_err_d;
  logic                        rsp_timeout_q, rsp_timeout_d;
  logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
  logic [TIMEOUT_W-1:0]        cnt_q, cnt_d;

  assign req_ready_o   = (state_q == ST_IDLE) && !HRESET;
  assign busy_o        = (state_q != ST_IDLE);
  assign PSEL          = psel_q;
  assign PENABLE       = penable_q;
  assign PWRITE        = pwrite_q;
  assign PADDR         = paddr_q;
  assign PWDATA        = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign rsp_rdata_o   = rsp_rdata_q;

  // Next-state and next-output computation for the transfer FSM
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_addr_i[1:0] == 2'b00) begin
            paddr_d   = req_addr_i;
            pwrite_d  = req_we_i;
            pwdata_d  = req_we_i ? req_wdata_i : '0;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_SETUP;
          end else begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
            state_d       = ST_RESP;
          end
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          // Completion takes priority over a timeout that lands on the same cycle.
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
          state_d       = ST_RESP;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = ST_RESP;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered-output flops with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_port.sv
// Directed, table-driven bench for apb_master_port (timeout limit set to 4).
module tb_apb_master_port;

  logic        HCLK;
  logic        HRESET;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic        req_we_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_master_port #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_W(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          waits;      // ACCESS cycles with PREADY low before PREADY high
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_psel;   // cycles with PSEL high
    int          exp_access; // cycles with PSEL and PENABLE high
    int          exp_lat;    // edges from handshake to rsp_valid_o visible
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int          cyc;
    int          psel_n;
    int          acc_n;
    bit          stable_ok;
    bit          done;
    logic [31:0] exp_pwdata;
    exp_pwdata = v.we ? v.wdata : 32'h0;
    @(negedge HCLK);
    req_valid_i = 1'b1; req_addr_i = v.addr; req_we_i = v.we; req_wdata_i = v.wdata;
    rsp_ready_i = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    check($sformatf("v%0d_idle_ready", id), req_ready_o, 1);
    @(posedge HCLK); #1;
    req_valid_i = 1'b0; req_addr_i = 12'hAA8; req_wdata_i = 32'hFFFF_FFFF;
    cyc = 0; psel_n = 0; acc_n = 0; stable_ok = 1'b1; done = 1'b0;
    while (!done) begin
      if (rsp_valid_o === 1'b1 || cyc >= 40) begin
        done = 1'b1;
      end else begin
        if (PSEL === 1'b1) begin
          psel_n++;
          if (PADDR !== v.addr || PWRITE !== v.we || PWDATA !== exp_pwdata) stable_ok = 1'b0;
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h1111_1111;
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
          if (acc_n == v.waits) begin
            PREADY = 1'b1; PSLVERR = v.slverr; PRDATA = v.prdata;
          end
          acc_n++;
        end
        @(posedge HCLK); #1;
        cyc++;
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    check($sformatf("v%0d_latency", id), cyc + 1, v.exp_lat);
    check($sformatf("v%0d_rsp_valid", id), rsp_valid_o, 1);
    check($sformatf("v%0d_rdata", id), rsp_rdata_o, v.exp_rdata);
    check($sformatf("v%0d_err", id), rsp_err_o, v.exp_err);
    check($sformatf("v%0d_timeout", id), rsp_timeout_o, v.exp_to);
    check($sformatf("v%0d_psel_cycles", id), psel_n, v.exp_psel);
    check($sformatf("v%0d_access_cycles", id), acc_n, v.exp_access);
    check($sformatf("v%0d_apb_stable", id), stable_ok, 1);
    check($sformatf("v%0d_resp_bus_idle", id), {PSEL, PENABLE}, 0);
    check($sformatf("v%0d_resp_ready", id), req_ready_o, 0);
    check($sformatf("v%0d_resp_busy", id), busy_o, 1);
    rsp_ready_i = 1'b1;
    @(posedge HCLK); #1;
    rsp_ready_i = 1'b0;
    check($sformatf("v%0d_drain_valid", id), rsp_valid_o, 0);
    check($sformatf("v%0d_drain_ready", id), req_ready_o, 1);
  endtask

  vec_t vecs[10];
  bit   bp_ok;
  bit   stale_ok;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           addr     we    wdata          wt  prdata         sl    exp_rdata      err   to    ps ac lat
    vecs[0] = '{12'h104, 1'b0, 32'h0000_0000, 0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1, 3};
    vecs[1] = '{12'h008, 1'b1, 32'h0000_0005, 3,  32'h7777_7777, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 5, 4, 6};
    vecs[2] = '{12'h0FC, 1'b0, 32'h0000_0000, 0,  32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 2, 1, 3};
    vecs[3] = '{12'h006, 1'b0, 32'h0000_0000, 0,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 1};
    vecs[4] = '{12'h200, 1'b0, 32'h0000_0000, 99, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 5, 4, 6};
    vecs[5] = '{12'h7FC, 1'b1, 32'hFFFF_FFFF, 99, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 5, 4, 6};
    vecs[6] = '{12'h00C, 1'b0, 32'h0000_0000, 3,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 5, 4, 6};
    vecs[7] = '{12'hFFC, 1'b1, 32'h1357_2468, 1,  32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 3, 2, 4};
    vecs[8] = '{12'h003, 1'b1, 32'h0000_0001, 0,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 1};
    vecs[9] = '{12'h100, 1'b0, 32'h0000_0000, 2,  32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0, 4, 3, 5};

    HRESET = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_wdata_i = '0;
    rsp_ready_i = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_ready_in_reset", req_ready_o, 0);
    check("rst_psel_penable_pwrite", {PSEL, PENABLE, PWRITE}, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_flags", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    check("rst_busy", busy_o, 0);
    HRESET = 1'b0;
    #1;
    check("rst_ready_after", req_ready_o, 1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Backpressure, then a request accepted on the cycle IDLE is re-entered
    @(negedge HCLK);
    req_valid_i = 1'b1; req_addr_i = 12'h010; req_we_i = 1'b0; req_wdata_i = 32'h0;
    @(posedge HCLK); #1;
    req_valid_i = 1'b0;
    @(posedge HCLK); #1;
    PREADY = 1'b1; PRDATA = 32'h1234_5678;
    @(posedge HCLK); #1;
    PREADY = 1'b0; PRDATA = 32'h0;
    check("bp_rsp_valid", rsp_valid_o, 1);
    check("bp_rdata", rsp_rdata_o, 32'h1234_5678);
    req_valid_i = 1'b1; req_addr_i = 12'h020; req_we_i = 1'b1; req_wdata_i = 32'hA5A5_0001;
    bp_ok = 1'b1;
    repeat (10) begin
      @(posedge HCLK); #1;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1234_5678 || rsp_err_o !== 1'b0 ||
          rsp_timeout_o !== 1'b0 || req_ready_o !== 1'b0 || PSEL !== 1'b0 || PENABLE !== 1'b0)
        bp_ok = 1'b0;
    end
    check("bp_hold_stable", bp_ok, 1);
    rsp_ready_i = 1'b1;
    @(posedge HCLK); #1;
    rsp_ready_i = 1'b0;
    check("bp_release_valid", rsp_valid_o, 0);
    check("bp_release_ready", req_ready_o, 1);
    @(posedge HCLK); #1;
    req_valid_i = 1'b0;
    check("b2b_setup", {PSEL, PENABLE}, 2'b10);
    check("b2b_paddr", PADDR, 12'h020);
    check("b2b_pwrite", PWRITE, 1);
    check("b2b_pwdata", PWDATA, 32'hA5A5_0001);
    @(posedge HCLK); #1;
    check("b2b_access", {PSEL, PENABLE}, 2'b11);
    PREADY = 1'b1;
    @(posedge HCLK); #1;
    PREADY = 1'b0;
    check("b2b_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 3'b100);
    check("b2b_rdata", rsp_rdata_o, 0);
    rsp_ready_i = 1'b1;
    @(posedge HCLK); #1;
    rsp_ready_i = 1'b0;

    // Reset during a stalled ACCESS discards the transfer
    @(negedge HCLK);
    req_valid_i = 1'b1; req_addr_i = 12'h040; req_we_i = 1'b0;
    @(posedge HCLK); #1;
    req_valid_i = 1'b0;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    check("mid_rst_in_access", {PSEL, PENABLE}, 2'b11);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    check("mid_rst_bus", {PSEL, PENABLE}, 0);
    check("mid_rst_rsp_valid", rsp_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_paddr", PADDR, 0);
    check("mid_rst_ready_held", req_ready_o, 0);
    HRESET = 1'b0;
    #1;
    check("mid_rst_ready_after", req_ready_o, 1);
    PREADY = 1'b1; PRDATA = 32'hBBBB_BBBB;
    stale_ok = 1'b1;
    repeat (6) begin
      @(posedge HCLK); #1;
      if (rsp_valid_o !== 1'b0 || PSEL !== 1'b0) stale_ok = 1'b0;
    end
    PREADY = 1'b0;
    check("mid_rst_no_stale", stale_ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
